// File: rtl/bcd_counter_2d.sv
// rtl/bcd_counter_2d.sv - two-digit BCD up/down counter with prescaler
// Digits always stay valid BCD below MODULO; tc and load_err are one-cycle registered pulses.
module bcd_counter_2d #(
  parameter int DIV    = 50_000_000,
  parameter int MODULO = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       tc,
  output logic       load_err
);

  localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
  localparam logic [3:0]     MAX_TENS  = 4'((MODULO - 1) / 10);
  localparam logic [3:0]     MAX_UNITS = 4'((MODULO - 1) % 10);
  localparam logic [7:0]     MOD_VAL   = 8'(MODULO);

  logic [PW-1:0] r_presc;
  logic [3:0]    r_tens;
  logic [3:0]    r_units;
  logic          r_tc;
  logic          r_load_err;

  logic          w_step;
  logic          w_at_max;
  logic          w_at_zero;
  logic [7:0]    w_load_val;
  logic          w_load_ok;
  logic [3:0]    w_nxt_tens;
  logic [3:0]    w_nxt_units;
  logic          w_wrap;

  // With DIV=1 the prescaler is permanently 0, so every enabled cycle is a step.
  assign w_step     = en && (r_presc == PRESC_MAX);
  assign w_at_max   = (r_tens == MAX_TENS) && (r_units == MAX_UNITS);
  assign w_at_zero  = (r_tens == 4'd0) && (r_units == 4'd0);
  assign w_load_val = ({4'd0, load_tens} * 8'd10) + {4'd0, load_units};
  assign w_load_ok  = (load_tens <= 4'd9) && (load_units <= 4'd9) && (w_load_val < MOD_VAL);

  always_comb begin
    w_nxt_tens  = r_tens;
    w_nxt_units = r_units;
    w_wrap      = 1'b0;
    if (up) begin
      if (w_at_max) begin
        w_nxt_tens  = 4'd0;
        w_nxt_units = 4'd0;
        w_wrap      = 1'b1;
      end else if (r_units == 4'd9) begin
        w_nxt_units = 4'd0;
        w_nxt_tens  = r_tens + 4'd1;
      end else begin
        w_nxt_units = r_units + 4'd1;
      end
    end else begin
      if (w_at_zero) begin
        w_nxt_tens  = MAX_TENS;
        w_nxt_units = MAX_UNITS;
        w_wrap      = 1'b1;
      end else if (r_units == 4'd0) begin
        w_nxt_units = 4'd9;
        w_nxt_tens  = r_tens - 4'd1;
      end else begin
        w_nxt_units = r_units - 4'd1;
      end
    end
  end

  // Priority clr > load > step > hold; a rejected load also freezes the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_tens     <= 4'd0;
      r_units    <= 4'd0;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
      if (clr) begin
        r_presc <= '0;
        r_tens  <= 4'd0;
        r_units <= 4'd0;
      end else if (load) begin
        if (w_load_ok) begin
          r_presc <= '0;
          r_tens  <= load_tens;
          r_units <= load_units;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (en) begin
        if (w_step) begin
          r_presc <= '0;
          r_tens  <= w_nxt_tens;
          r_units <= w_nxt_units;
          r_tc    <= w_wrap;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  assign tens     = r_tens;
  assign units    = r_units;
  assign tc       = r_tc;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_counter_2d.sv
// tb/tb_bcd_counter_2d.sv - bench for bcd_counter_2d
// Two instances (DIV=4/MODULO=60 and DIV=1/MODULO=100) share stimulus and are tracked by an integer model.
module tb_bcd_counter_2d;

  localparam int DIV_A = 4;
  localparam int MOD_A = 60;
  localparam int DIV_B = 1;
  localparam int MOD_B = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, clr, load;
  logic [3:0] load_tens, load_units;
  logic [3:0] tens_a, units_a, tens_b, units_b;
  logic       tc_a, tc_b, err_a, err_b;

  int checks   = 0;
  int failures = 0;
  int m_cnt[2];
  int m_psc[2];
  int e_tc[2];
  int e_err[2];
  int tc_cnt;
  int guard;
  logic [7:0] c0;

  always #5 clk = ~clk;

  bcd_counter_2d #(.DIV(DIV_A), .MODULO(MOD_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_tens(load_tens), .load_units(load_units),
    .tens(tens_a), .units(units_a), .tc(tc_a), .load_err(err_a)
  );

  bcd_counter_2d #(.DIV(DIV_B), .MODULO(MOD_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_tens(load_tens), .load_units(load_units),
    .tens(tens_b), .units(units_b), .tc(tc_b), .load_err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_psc[i] = 0;
      e_tc[i]  = 0;
      e_err[i] = 0;
    end
  endtask

  // Count kept as a plain integer 0..md-1; digits are derived by /10 and %10.
  task automatic model_step(input int i, input int md, input int dv);
    int v;
    int old;
    e_tc[i]  = 0;
    e_err[i] = 0;
    if (clr) begin
      m_cnt[i] = 0;
      m_psc[i] = 0;
    end else if (load) begin
      v = int'(load_tens) * 10 + int'(load_units);
      if (load_tens <= 9 && load_units <= 9 && v < md) begin
        m_cnt[i] = v;
        m_psc[i] = 0;
      end else begin
        e_err[i] = 1;
      end
    end else if (en) begin
      if (m_psc[i] == dv - 1) begin
        old = m_cnt[i];
        if (up) begin
          m_cnt[i] = (old + 1) % md;
          e_tc[i]  = (old == md - 1) ? 1 : 0;
        end else begin
          m_cnt[i] = (old + md - 1) % md;
          e_tc[i]  = (old == 0) ? 1 : 0;
        end
      end
      m_psc[i] = (m_psc[i] + 1) % dv;
    end
  endtask

  task automatic check_all();
    check("a_tens",  tens_a,  m_cnt[0] / 10);
    check("a_units", units_a, m_cnt[0] % 10);
    check("a_tc",    tc_a,    e_tc[0]);
    check("a_err",   err_a,   e_err[0]);
    check("b_tens",  tens_b,  m_cnt[1] / 10);
    check("b_units", units_b, m_cnt[1] % 10);
    check("b_tc",    tc_b,    e_tc[1]);
    check("b_err",   err_b,   e_err[1]);
  endtask

  task automatic cyc(input logic e, input logic u, input logic c, input logic l,
                     input logic [3:0] lt, input logic [3:0] lu);
    en = e; up = u; clr = c; load = l; load_tens = lt; load_units = lu;
    model_step(0, MOD_A, DIV_A);
    model_step(1, MOD_B, DIV_B);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_to_psc(input int target);
    guard = 0;
    while (m_psc[0] != target && guard < 8) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      guard++;
    end
    check("psc_reach", (m_psc[0] == target) ? 1 : 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0;
    load_tens = 4'd0; load_units = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // count up 00..59 over 240 clocks, one wrap
    tc_cnt = 0;
    for (int k = 0; k < 240; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      if (tc_a) tc_cnt++;
    end
    check("t1_tc_count", tc_cnt, 1);
    check("t1_end", {tens_a, units_a}, 8'h00);

    // load 58 then count down to 00 and wrap to 59
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd8);
    check("t2_load", {tens_a, units_a}, 8'h58);
    tc_cnt = 0;
    for (int k = 0; k < 236; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      if (tc_a) tc_cnt++;
    end
    check("t2_tc_count", tc_cnt, 1);
    check("t2_end", {tens_a, units_a}, 8'h59);
    check("t2_tc_last", tc_a, 1);

    // rejected loads
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd3);
    check("t3_err73", err_a, 1);
    check("t3_hold73", {tens_a, units_a}, 8'h59);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t3_err_pulse", err_a, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd10);
    check("t3_err0A", err_a, 1);
    check("t3_err0A_b", err_b, 1);
    check("t3_hold0A", {tens_a, units_a}, 8'h59);

    // clr+load on a step cycle, then load on a step cycle
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd9);
    run_to_psc(3);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd9);
    check("t4_clr_step", {tens_a, units_a}, 8'h00);
    check("t4_clr_tc", tc_a, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd9);
    run_to_psc(3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd9);
    check("t4_load_step", {tens_a, units_a}, 8'h09);
    check("t4_load_tc", tc_a, 0);

    // freeze prescaler at 2 for 10 clocks
    run_to_psc(2);
    c0 = {tens_a, units_a};
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t5_frozen", {tens_a, units_a}, c0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t5_resume1", {tens_a, units_a}, 8'h09);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t5_resume2", {tens_a, units_a}, 8'h10);

    // MODULO=100 DIV=1 wrap 99->00
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 4'd8);
    check("t6_load98", {tens_b, units_b}, 8'h98);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t6_99", {tens_b, units_b}, 8'h99);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    check("t6_00", {tens_b, units_b}, 8'h00);
    check("t6_tc", tc_b, 1);
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

    // async reset between clock edges
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_b_tens", tens_b, 0);
    check("rst_b_units", units_b, 0);
    check("rst_a_digits", {tens_a, units_a}, 0);
    check("rst_flags", {tc_a, tc_b, err_a, err_b}, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cyc(($urandom % 8) != 0, 1'($urandom % 2), ($urandom % 64) == 0,
          ($urandom % 32) == 0, 4'($urandom % 12), 4'($urandom % 12));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
